// File: rtl/fft_mag_buf.sv
// FFT output magnitude stage: |X| ~ max + min/2 in a 3-stage pipeline,
// written into a ping-pong spectrum buffer read by the display side.
module fft_mag_buf #(
  parameter int DW    = 16,
  parameter int FFT_N = 256,
  parameter int AW    = 8
) (
  input  logic          clk_50m,
  input  logic          rst_n,
  input  logic          src_valid,
  input  logic          src_sop,
  input  logic          src_eop,
  input  logic [DW-1:0] src_re,
  input  logic [DW-1:0] src_im,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          frame_ready,
  output logic          bank_sel,
  output logic [15:0]   frame_cnt,
  output logic          err_len
);
  localparam int            STAGES = 3;
  localparam logic [AW-1:0] LAST   = AW'(FFT_N - 1);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  logic [STAGES:1] r_vld_pipe, r_sop_pipe, r_eop_pipe;
  logic [DW-1:0]   r_a, r_b, r_mx, r_mn, r_mag;
  logic [DW-1:0]   w_abs_re, w_abs_im;
  logic [DW-1:0]   r_ram [2*FFT_N];
  logic [DW-1:0]   r_rd_data;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_wr_cnt, w_cnt_nxt, w_waddr;
  logic            w_we, w_err, w_commit;
  logic            r_bank_sel, r_err_len;
  logic [15:0]     r_frame_cnt;
  logic            w_v, w_sop, w_eop;

  // Two's complement negate of the most negative value yields 2^(DW-1),
  // which is exactly right when the result is read as unsigned.
  assign w_abs_re = src_re[DW-1] ? (~src_re + 1'b1) : src_re;
  assign w_abs_im = src_im[DW-1] ? (~src_im + 1'b1) : src_im;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_sop_pipe <= '0;
      r_eop_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], src_valid};
      r_sop_pipe <= {r_sop_pipe[STAGES-1:1], src_valid & src_sop};
      r_eop_pipe <= {r_eop_pipe[STAGES-1:1], src_valid & src_eop};
    end
  end

  always_ff @(posedge clk_50m) begin
    r_a   <= w_abs_re;
    r_b   <= w_abs_im;
    r_mx  <= (r_a >= r_b) ? r_a : r_b;
    r_mn  <= (r_a >= r_b) ? r_b : r_a;
    r_mag <= r_mx + (r_mn >> 1);
  end

  assign w_v   = r_vld_pipe[STAGES];
  assign w_sop = r_sop_pipe[STAGES];
  assign w_eop = r_eop_pipe[STAGES];

  // FSM: state register
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state and write control, evaluated on S3 beats
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = r_wr_cnt;
    w_cnt_nxt   = r_wr_cnt;
    w_err       = 1'b0;
    case (r_state)
      IDLE, COMMIT: begin
        // COMMIT behaves like IDLE for the beat it sees, so a sop here
        // starts the next frame in the freshly swapped fill bank.
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        if (w_v && w_sop) begin
          w_state_nxt = FILL;
          w_we        = 1'b1;
          w_waddr     = '0;
          w_cnt_nxt   = AW'(1);
        end
      end
      FILL: begin
        if (w_v) begin
          w_we = 1'b1;
          if (w_sop) begin
            w_err     = 1'b1;
            w_waddr   = '0;
            w_cnt_nxt = AW'(1);
          end else if (w_eop || r_wr_cnt == LAST) begin
            w_cnt_nxt = '0;
            if (w_eop && r_wr_cnt == LAST) w_state_nxt = COMMIT;
            else begin
              w_err       = 1'b1;
              w_state_nxt = IDLE;
            end
          end else begin
            w_cnt_nxt = r_wr_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_commit = (r_state == FILL) && (w_state_nxt == COMMIT);

  // FSM: outputs
  always_comb begin
    frame_ready = (r_state == COMMIT);
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt    <= '0;
      r_bank_sel  <= 1'b0;
      r_frame_cnt <= '0;
      r_err_len   <= 1'b0;
    end else begin
      r_wr_cnt    <= w_cnt_nxt;
      r_bank_sel  <= r_bank_sel ^ w_commit;
      r_frame_cnt <= r_frame_cnt + {15'd0, w_commit};
      r_err_len   <= w_err;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (w_we) r_ram[{~r_bank_sel, w_waddr}] <= r_mag;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_ram[{r_bank_sel, rd_addr}];
  end

  assign rd_data   = r_rd_data;
  assign bank_sel  = r_bank_sel;
  assign frame_cnt = r_frame_cnt;
  assign err_len   = r_err_len;
endmodule

// File: tb/tb_fft_mag_buf.sv
// Bench for fft_mag_buf: randomized frames checked every cycle against a
// frame-level reference, plus literal checks on known cases.
module tb_fft_mag_buf;
  localparam int DW = 16, FFT_N = 256, AW = 8;

  logic          clk_50m = 0;
  logic          rst_n = 0;
  logic          src_valid = 0, src_sop = 0, src_eop = 0;
  logic [DW-1:0] src_re = 0, src_im = 0;
  logic [AW-1:0] rd_addr = 0;
  logic [DW-1:0] rd_data;
  logic          frame_ready, bank_sel, err_len;
  logic [15:0]   frame_cnt;

  fft_mag_buf #(.DW(DW), .FFT_N(FFT_N), .AW(AW)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .src_valid(src_valid), .src_sop(src_sop),
    .src_eop(src_eop), .src_re(src_re), .src_im(src_im), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_ready(frame_ready), .bank_sel(bank_sel),
    .frame_cnt(frame_cnt), .err_len(err_len));

  always #10 clk_50m = ~clk_50m;

  int vectors = 0, miscompares = 0;
  int n_fr = 0, n_err = 0;

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int mag_of(int re, int im);
    int a, b;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    return (a > b) ? a + b / 2 : b + a / 2;
  endfunction

  // Reference: beats take effect 3 edges after capture; frames are collected
  // as lists and published to the display image on a correct-length commit.
  typedef struct {bit v; bit sop; bit eop; int mag;} beat_t;
  beat_t pq[$];
  beat_t nb, ob;
  int    fbuf[$];
  int    disp [FFT_N];
  bit    filling = 0, disp_ok = 0;
  bit    m_fr = 0, m_err = 0, m_bank = 0, m_rd_ok = 1;
  int    m_fcnt = 0, m_rd = 0;

  always @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      pq.delete(); fbuf.delete();
      filling = 0; disp_ok = 0; m_fr = 0; m_err = 0; m_bank = 0;
      m_fcnt = 0; m_rd = 0; m_rd_ok = 1;
    end else begin
      m_rd_ok = disp_ok;
      m_rd    = disp[rd_addr];
      nb.v = src_valid; nb.sop = src_valid & src_sop; nb.eop = src_valid & src_eop;
      nb.mag = mag_of(int'($signed(src_re)), int'($signed(src_im)));
      pq.push_back(nb);
      m_fr = 0; m_err = 0;
      if (pq.size() > 3) begin
        ob = pq.pop_front();
        if (ob.v) begin
          if (ob.sop) begin
            if (filling) m_err = 1;
            filling = 1;
            fbuf.delete();
            fbuf.push_back(ob.mag);
          end else if (filling) begin
            fbuf.push_back(ob.mag);
            if (ob.eop || fbuf.size() == FFT_N) begin
              filling = 0;
              if (ob.eop && fbuf.size() == FFT_N) begin
                for (int i = 0; i < FFT_N; i++) disp[i] = fbuf[i];
                disp_ok = 1; m_fr = 1; m_bank = ~m_bank;
                m_fcnt = (m_fcnt + 1) & 16'hFFFF;
              end else m_err = 1;
            end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_50m);
    if (rst_n) begin
      n_fr  += int'(frame_ready);
      n_err += int'(err_len);
      chk("frame_ready", int'(frame_ready), int'(m_fr));
      chk("err_len", int'(err_len), int'(m_err));
      chk("bank_sel", int'(bank_sel), int'(m_bank));
      chk("frame_cnt", int'(frame_cnt), m_fcnt);
      if (m_rd_ok) chk("rd_data", int'(rd_data), m_rd);
    end
  end

  bit           rd_force = 0;
  logic [AW-1:0] rd_fix = 0;
  initial forever begin
    @(negedge clk_50m);
    rd_addr = rd_force ? rd_fix : AW'($urandom);
  end

  int cre[4] = '{3, -32768, 0, 100};
  int cim[4] = '{-4, -32768, -1, 100};

  task automatic frame(int n, int mode, int sop2, bit gaps, bit eop_en);
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(2) == 0) begin
        @(negedge clk_50m);
        src_valid = 0; src_sop = 0; src_eop = 0;
      end
      @(negedge clk_50m);
      src_valid = 1;
      src_sop   = (i == 0) || (i == sop2);
      src_eop   = eop_en && (i == n - 1);
      if (mode == 0) begin
        src_re = DW'(i); src_im = '0;
      end else if (mode == 2 && i < 4) begin
        src_re = cre[i][15:0]; src_im = cim[i][15:0];
      end else begin
        src_re = DW'($urandom); src_im = DW'($urandom);
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk_50m);
      src_valid = 0; src_sop = 0; src_eop = 0;
    end
  endtask

  task automatic read_lit(string nm, int addr, int exp);
    rd_fix = AW'(addr); rd_force = 1;
    @(negedge clk_50m);
    @(negedge clk_50m);
    chk(nm, int'(rd_data), exp);
    rd_force = 0;
  endtask

  task automatic reset_check();
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_frame_ready", int'(frame_ready), 0);
    chk("rst_bank_sel", int'(bank_sel), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_err_len", int'(err_len), 0);
  endtask

  initial begin
    int r;
    #25 reset_check();
    repeat (3) @(negedge clk_50m);
    rst_n = 1;
    idle(2);

    // ramp frame
    frame(256, 0, -1, 0, 1); idle(6);
    chk("t1_frame_cnt", int'(frame_cnt), 1);
    chk("t1_bank_sel", int'(bank_sel), 1);
    chk("t1_n_ready", n_fr, 1);
    read_lit("t1_rd7", 7, 7);
    read_lit("t1_rd255", 255, 255);

    // magnitude corners
    frame(256, 2, -1, 0, 1); idle(6);
    read_lit("t2_corner0", 0, 5);
    read_lit("t2_corner1", 1, 49152);
    read_lit("t2_corner2", 2, 1);
    read_lit("t2_corner3", 3, 150);
    chk("t2_bank_sel", int'(bank_sel), 0);

    // short frame is dropped, display unchanged
    frame(101, 1, -1, 0, 1); idle(6);
    chk("t3_n_err", n_err, 1);
    chk("t3_frame_cnt", int'(frame_cnt), 2);
    read_lit("t3_rd_prev", 1, 49152);

    // back-to-back, with and without gaps
    frame(256, 1, -1, 1, 1); frame(256, 1, -1, 1, 1);
    frame(256, 1, -1, 0, 1); frame(256, 1, -1, 0, 1); idle(6);
    chk("t4_frame_cnt", int'(frame_cnt), 6);
    chk("t4_bank_sel", int'(bank_sel), 0);
    chk("t4_n_ready", n_fr, 6);

    // sop in mid-frame restarts
    frame(306, 1, 50, 0, 1); idle(6);
    chk("t5_n_err", n_err, 2);
    chk("t5_frame_cnt", int'(frame_cnt), 7);

    // reset mid-frame
    frame(128, 1, -1, 0, 0);
    @(negedge clk_50m);
    src_valid = 0; rst_n = 0;
    #2 reset_check();
    idle(2);
    rst_n = 1;
    frame(256, 1, -1, 1, 1); idle(6);
    chk("t6_frame_cnt", int'(frame_cnt), 1);
    chk("t6_bank_sel", int'(bank_sel), 1);

    // random mix
    for (int f = 0; f < 14; f++) begin
      r = $urandom_range(9);
      if (r < 7)       frame(256, 1, -1, $urandom_range(1), 1);
      else if (r == 7) frame($urandom_range(1, 255), 1, -1, $urandom_range(1), 1);
      else if (r == 8) frame(300, 1, -1, $urandom_range(1), 1);
      else             frame(256 + 60, 1, $urandom_range(1, 60), $urandom_range(1), 1);
      idle($urandom_range(3));
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
